// File: rtl/dram_uart_dump.sv
// dram_uart_dump: walks a 1-bit distributed RAM, packs bits LSB-first into bytes and streams them as 8N1 UART
module dram_uart_dump #(
  parameter int DEPTH        = 128,
  parameter int ADDR_W       = 7,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_do,
  output logic              ram_lock,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  logic [2:0] state;
  logic [7:0] data;
  logic [2:0] bit_cnt;
  logic [BW-1:0] baud;
  logic baud_end;
  assign baud_end = baud == BAUD_MAX;
  assign busy = state != IDLE;
  assign ram_lock = busy;
  // FSM: fetch 8 RAM bits, then shift the byte out; tx is updated together with state so it stays registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ram_addr <= '0;
      data <= '0;
      bit_cnt <= '0;
      baud <= '0;
      tx <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          ram_addr <= '0;
        end
        FETCH: begin
          data[ram_addr[2:0]] <= ram_do;
          ram_addr <= ram_addr == ADDR_MAX ? '0 : ram_addr + ADDR_W'(1);
          if (&ram_addr[2:0]) begin
            state <= START;
            tx <= 1'b0;
            baud <= '0;
          end
        end
        START: if (baud_end) begin
          baud <= '0;
          state <= DATA;
          bit_cnt <= '0;
          tx <= data[0];
        end else baud <= baud + BW'(1);
        DATA: if (baud_end) begin
          baud <= '0;
          if (&bit_cnt) begin
            state <= STOP;
            tx <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx <= data[bit_cnt + 3'd1];
          end
        end else baud <= baud + BW'(1);
        STOP: if (baud_end) begin
          baud <= '0;
          state <= ram_addr == '0 ? IDLE : FETCH;
          done <= ram_addr == '0;
        end else baud <= baud + BW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_uart_dump.sv
// tb_dram_uart_dump: scoreboard bench with a RAM model and a UART receiver monitor
module tb_dram_uart_dump;
  localparam int CPB = 4;
  logic clk, rst_n, start, we, wd;
  logic [6:0] wa;
  logic [6:0] ram_addr;
  logic ram_do, ram_lock, tx, busy, done;
  logic [127:0] mem, img;
  logic [7:0] scb[$];
  int checks = 0, failures = 0, frames = 0, busy_cycles = 0, done_cnt = 0;

  dram_uart_dump #(.DEPTH(128), .ADDR_W(7), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ram_addr(ram_addr), .ram_do(ram_do),
    .ram_lock(ram_lock), .tx(tx), .busy(busy), .done(done)
  );

  // RAM model: async read, write gated by the lock exactly as in the test top
  assign ram_do = mem[ram_addr];
  always @(posedge clk) if (we && !ram_lock) mem[wa] <= wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(logic [127:0] v);
    for (int i = 0; i < 128; i++) begin
      we = 1'b1; wa = 7'(i); wd = v[i];
      @(posedge clk); #1;
    end
    we = 1'b0;
  endtask

  task automatic push_img(logic [127:0] v);
    for (int k = 0; k < 16; k++) scb.push_back(v[8*k +: 8]);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n == 2000) begin
      checks++; failures++;
      $display("FAIL %s: done not seen within 2000 cycles", name);
    end
  endtask

  // busy/done activity counters
  initial forever begin
    @(negedge clk);
    if (busy) busy_cycles++;
    if (done) done_cnt++;
  end

  // UART receiver: samples mid-bit, aborts on reset, pops and compares each frame
  initial begin
    logic act;
    int cnt, j;
    logic [7:0] rx, exp;
    act = 1'b0; cnt = 0; rx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) act = 1'b0;
      else if (!act) begin
        if (!tx) begin act = 1'b1; cnt = 0; end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          j = (cnt - CPB / 2) / CPB;
          if (j >= 1 && j <= 8) rx[j-1] = tx;
          if (j == 9) begin
            act = 1'b0;
            frames++;
            checks++;
            if (scb.size() == 0) begin
              failures++;
              $display("FAIL frame: unexpected byte %0h", rx);
            end else begin
              exp = scb.pop_front();
              if (rx !== exp || tx !== 1'b1) begin
                failures++;
                $display("FAIL frame: got %0h stop=%0b expected %0h stop=1", rx, tx, exp);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int b0, d0, f0, n;
    rst_n = 1'b0; start = 1'b0; we = 1'b0; wa = '0; wd = 1'b0;
    @(posedge clk); #1;
    img = 128'b10;
    load(img);
    // reset with start held: must stay idle
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_addr", ram_addr, 0); chk("rst_lock", ram_lock, 0);
    end
    // basic dump: byte0=0x02, rest zero
    scb.push_back(8'h02);
    for (int k = 1; k < 16; k++) scb.push_back(8'h00);
    @(posedge clk); #1;
    b0 = busy_cycles; d0 = done_cnt; f0 = frames;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", busy, 1); chk("accept_lock", ram_lock, 1);
    wait_done("basic");
    @(posedge clk); #1;
    chk("basic_busy_len", busy_cycles - b0, 768);
    chk("basic_done_cnt", done_cnt - d0, 1);
    chk("basic_frames", frames - f0, 16);
    // bit order plus locked write and ignored start
    img = '0; img[127] = 1'b1; img[8] = 1'b1;
    load(img);
    for (int k = 0; k < 16; k++) scb.push_back(k == 1 ? 8'h01 : k == 15 ? 8'h80 : 8'h00);
    b0 = busy_cycles; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk); #1;
    start = 1'b1; we = 1'b1; wa = 7'd8; wd = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("lock_during", ram_lock, 1);
    start = 1'b0; we = 1'b0;
    wait_done("lock");
    @(posedge clk); #1;
    chk("lock_mem", mem, img);
    chk("lock_busy_len", busy_cycles - b0, 768);
    chk("lock_done_cnt", done_cnt - d0, 1);
    repeat (5) @(posedge clk); #1;
    chk("lock_idle", busy, 0);
    // reset during DATA bit 3 of byte 5 (byte5=0xBA, bit3=1)
    img = 128'h0123456789ABCDEF_FEDCBA9876543210;
    load(img);
    push_img(img);
    f0 = frames;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (frames - f0 < 5 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("mid_five_frames", frames - f0, 5);
    n = 0;
    while (tx && n < 100) begin @(posedge clk); #1; n++; end
    chk("mid_start_bit", tx, 0);
    repeat (17) @(posedge clk); #1;
    chk("mid_bit3", tx, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_tx", tx, 1); chk("mid_busy", busy, 0); chk("mid_lock", ram_lock, 0);
    chk("mid_addr", ram_addr, 0);
    scb.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("mid_idle_tx", tx, 1);
    push_img(img);
    f0 = frames;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("after_reset");
    @(posedge clk); #1;
    chk("after_reset_frames", frames - f0, 16);
    // back-to-back with start held high
    img = 128'h00FF_1234_5678_9ABC_DEF0_0F0F_C3C3_8001;
    load(img);
    push_img(img); push_img(img);
    f0 = frames; d0 = done_cnt;
    start = 1'b1;
    wait_done("b2b_first");
    chk("b2b_gap_tx", tx, 1); chk("b2b_gap_busy", busy, 0);
    @(negedge clk);
    chk("b2b_restart_busy", busy, 1); chk("b2b_restart_tx", tx, 1); chk("b2b_done_pulse", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_second");
    @(posedge clk); #1;
    chk("b2b_frames", frames - f0, 32);
    chk("b2b_done_cnt", done_cnt - d0, 2);
    chk("scb_empty", scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
